// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin sharing of one register-file write port between two requesters.
// Optional REGARB_INIT_SWEEP_EN zero-fills all 2**AW registers after reset before arbitration starts.
module reg_wr_arbiter #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          C,
    input  logic          W0_Req,
    input  logic [AW-1:0] W0_RW,
    input  logic [DW-1:0] W0_Data,
    output logic          W0_Gnt,
    input  logic          W1_Req,
    input  logic [AW-1:0] W1_RW,
    input  logic [DW-1:0] W1_Data,
    output logic          W1_Gnt,
    output logic          RegW,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] BusW,
    output logic          Busy
);
    // Handshake: a requester holds Req/RW/Data stable until it sees Gnt=1 at a rising edge;
    // that edge commits the write to RegW/RW/BusW, and the requester may then move on.
    logic          regw_q, regw_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] busw_q, busw_d;
    logic          last_q, last_d;   // 1: requester 1 was granted most recently
    logic          in_sweep;
    logic [AW-1:0] sweep_addr;

`ifdef REGARB_INIT_SWEEP_EN
    typedef enum logic {SWEEP, ARB} state_e;
    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    assign in_sweep   = (state_q == SWEEP);
    assign sweep_addr = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SWEEP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
                state_d = ARB;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (C) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign in_sweep   = 1'b0;
    assign sweep_addr = '0;
`endif

    always_comb begin
        W0_Gnt = 1'b0;
        W1_Gnt = 1'b0;
        regw_d = 1'b0;
        rw_d   = rw_q;
        busw_d = busw_q;
        last_d = last_q;
        if (!C && !in_sweep) begin
            if (W0_Req && (!W1_Req || last_q)) begin
                W0_Gnt = 1'b1;
            end else if (W1_Req) begin
                W1_Gnt = 1'b1;
            end
        end
        if (in_sweep) begin
            regw_d = 1'b1;
            rw_d   = sweep_addr;
            busw_d = '0;
        end else if (W0_Gnt) begin
            regw_d = 1'b1;
            rw_d   = W0_RW;
            busw_d = W0_Data;
            last_d = 1'b0;
        end else if (W1_Gnt) begin
            regw_d = 1'b1;
            rw_d   = W1_RW;
            busw_d = W1_Data;
            last_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (C) begin
            regw_q <= 1'b0;
            rw_q   <= '0;
            busw_q <= '0;
            last_q <= 1'b1;
        end else begin
            regw_q <= regw_d;
            rw_q   <= rw_d;
            busw_q <= busw_d;
            last_q <= last_d;
        end
    end

    assign RegW = regw_q;
    assign RW   = rw_q;
    assign BusW = busw_q;
    assign Busy = in_sweep;
endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter DW, default 32: data width of write data and BusW.
REQ-002 Parameter AW, default 4: register address width; the register count is 2**AW (16).
REQ-003 CLK  in  1  system clock; all state updates on the rising edge.
REQ-004 C  in  1  reset, synchronous, active-high.
REQ-005 W0_Req  in  1  requester 0 (pipeline writeback) write request.
REQ-006 W0_RW  in  AW  requester 0 destination register.
REQ-007 W0_Data  in  DW  requester 0 write data.
REQ-008 W0_Gnt  out  1  requester 0 grant.
REQ-009 W1_Req  in  1  requester 1 (multi-cycle/load unit) write request.
REQ-010 W1_RW  in  AW  requester 1 destination register.
REQ-011 W1_Data  in  DW  requester 1 write data.
REQ-012 W1_Gnt  out  1  requester 1 grant.
REQ-013 RegW  out  1  register-file write enable, registered.
REQ-014 RW  out  AW  register-file write address, registered.
REQ-015 BusW  out  DW  register-file write data, registered.
REQ-016 Busy  out  1  high while the init sweep runs; grants are blocked.
REQ-017 One clock; reset is synchronous and active-high.

Function
REQ-018 States: SWEEP (zero-initialise the register file) and ARB (share the single write port between the two requesters).
REQ-019 In ARB, W0_Gnt and W1_Gnt are combinational from state, W0_Req, W1_Req and the round-robin pointer.
REQ-020 At most one grant is high in any cycle.
REQ-021 Only one requester asserting Req: that requester is granted in the same cycle.
REQ-022 Both requesters asserting Req: the requester not granted most recently is granted.
REQ-023 The round-robin pointer updates only on a cycle in which a grant is issued.
REQ-024 Granted in cycle t: on the edge ending cycle t, RegW<=1, RW<=granted RW and BusW<=granted Data; latency is 1 cycle.
REQ-025 No grant in a cycle: RegW<=0 on the next edge; RW and BusW hold their previous values.
REQ-026 A requester holds Req, RW and Data stable until it samples Gnt=1 at a clock edge; a Req dropped before grant is lost with no write.
REQ-027 Back-to-back grants are allowed: a continuously requesting single requester is granted every cycle, giving full port throughput.
REQ-028 Both requesters targeting the same RW: both writes occur in round-robin order; the later write wins, and no merging or ordering beyond arbitration is provided.
REQ-029 In SWEEP, W0_Gnt=W1_Gnt=0 and Busy=1.
REQ-030 SWEEP counter: each edge with C=0 issues RegW<=1, RW<=counter, BusW<=0 and increments the counter.
REQ-031 The edge that issues RW=2**AW-1 moves the state to ARB and drives Busy to 0 on that same edge.
REQ-032 Requests made during SWEEP are held off, not dropped, per REQ-026.

Reset
REQ-033 While C=1 at an edge: RegW<=0, RW<=0, BusW<=0, sweep counter<=0 and round-robin pointer<=requester 1, so requester 0 wins the first conflict.
REQ-034 With the sweep compiled in, reset sets state<=SWEEP and Busy<=1; without it, reset sets state<=ARB and Busy<=0.
REQ-035 C asserted mid-sweep restarts the sweep from register 0; C asserted mid-arbitration discards any pending grant, and no write is issued on that edge.
REQ-036 Grants are 0 in every cycle in which C=1.

Configuration
REQ-037 Macro REGARB_INIT_SWEEP_EN. Defined: SWEEP state and counter are present and behave per REQ-029 to REQ-032.
REQ-038 Macro REGARB_INIT_SWEEP_EN not defined: no SWEEP state, Busy is tied to 0, and arbitration starts in the first cycle after C falls.

Verification
REQ-039 Sweep: C high 2 cycles then low -> RegW=1 with RW=0..15 and BusW=0 on 16 consecutive edges; Busy falls with RW=15; an early W0_Req is granted only afterwards.
REQ-040 Single requester: W0_Req=1, W0_RW=5, W0_Data=32'hDEADBEEF -> W0_Gnt=1 same cycle; next edge RegW=1, RW=5, BusW=32'hDEADBEEF.
REQ-041 Conflict: both Req high for 4 cycles (RW 3 and 9) -> grants alternate W0, W1, W0, W1; RW sequence 3, 9, 3, 9.
REQ-042 Reset mid-sweep: C pulsed after RW=7 issued -> next sweep restarts at RW=0 and completes all 16 writes.
REQ-043 Idle: no requests for 3 cycles -> RegW=0 and RW/BusW unchanged; with the macro undefined, W1_Req in the first post-reset cycle -> W1_Gnt=1 immediately.
